lfsr_check: RTL and testbench
=============================

Name: lfsr_check

Overview:
- Receive-side checker for the 8-bit LFSR generator stream. Consumes one sample per `valid_i` cycle.
- Seeds its own LFSR model from the first accepted sample, predicts each following sample, and reports lock, errors and measured sequence period.
- Sits at the far end of a link or loopback path fed by the LFSR generator. Used for built-in self-test of that path.

Parameters:
- LOCK_CNT, 4, consecutive matching samples required before `lock_o` asserts (1..15).
- ERR_LIMIT, 3, consecutive mismatches that force the LOST state (1..15).
- CNT_W, 16, width of `err_cnt_o` and of the internal sample counter.

Ports:
- clk_i  input  1  clock; all logic on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- start_i  input  1  level enable; low returns the block to IDLE.
- data_i  input  8  received LFSR sample.
- valid_i  input  1  `data_i` is valid this cycle.
- lock_o  output  1  checker is locked to the sequence.
- err_o  output  1  one-cycle pulse per mismatched or rejected sample.
- err_cnt_o  output  CNT_W  total mismatches since start; saturates at all-ones.
- wrap_o  output  1  one-cycle pulse when the seed value recurs.
- period_o  output  CNT_W  samples between seed and its recurrence; 0 until the first wrap.
- lost_o  output  1  high while in the LOST state.
- err_sticky_o  output  1  sticky error flag (see Optional Feature).

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, ports `clk_i` / `rst_i`.
- Reset values: all outputs 0, state IDLE, model register 0.
- LFSR model (fixed): Fibonacci, x^8+x^6+x^5+x^4+1, maximal length, period 255.
  - next(q) = {q[6:0], q[7]^q[5]^q[4]^q[3]}.
  - Example chain: 0xAA -> 0x55 -> 0xAB.
- Timing: outputs are registered. The response to a sample is visible the cycle after the edge at which `valid_i` = 1. Cycles with `valid_i` = 0 change nothing.
- IDLE:
  - Counters and `period_o` hold.
  - `start_i` = 1 -> SEED. On entry to SEED: `err_cnt_o`, `period_o`, the sample counter and the match/mismatch counters are cleared; `lock_o` = 0; `lost_o` = 0.
- SEED, on a valid sample:
  - Nonzero sample: first_val <= data_i, exp <= next(data_i), sample_cnt <= 1, match_cnt <= 1; go to TRACK.
  - `data_i` == 0x00: this is the LFSR lockup state. The sample is rejected, `err_o` pulses, `err_cnt_o` does not change, and the block stays in SEED.
- TRACK, on a valid sample; sample_cnt increments saturating in both cases:
  - Match (`data_i` == exp):
    - exp <= next(exp); mismatch_run <= 0; match_cnt increments, saturating at LOCK_CNT.
    - `lock_o` <= 1 once match_cnt reaches LOCK_CNT.
  - Match and `data_i` == first_val, with sample_cnt > 1:
    - `wrap_o` pulses; `period_o` <= sample_cnt; sample_cnt <= 1.
    - A second wrap overwrites `period_o`.
  - Mismatch:
    - `err_o` pulses; `err_cnt_o` increments, saturating.
    - `lock_o` <= 0; match_cnt <= 0; mismatch_run increments.
    - Resync: exp <= next(data_i).
    - mismatch_run reaching ERR_LIMIT -> LOST.
- LOST:
  - `lost_o` = 1, `lock_o` = 0; samples are ignored and counters hold.
  - Exit is only via `start_i` low (-> IDLE) then high.
- `start_i` low in any state -> IDLE on the next edge.
  - `lock_o` and `lost_o` clear.
  - `err_cnt_o` and `period_o` hold for readout.
- Simultaneous events:
  - `rst_i` dominates `start_i` and `valid_i`.
  - A valid sample arriving on the same edge that `start_i` falls is ignored.
- Reset mid-operation: full return to the reset values above within one cycle.

Optional Feature:
- LFSR_CHECK_STICKY_EN defined:
  - `err_sticky_o` sets on any `err_o` pulse.
  - It clears only on `rst_i` or on the IDLE->SEED transition.
- Undefined: `err_sticky_o` is tied to 0 and no sticky register is built.

Test Plan:
1. Reset, `start_i` = 1, feed the correct sequence from seed 0xAA (0xAA, 0x55, 0xAB, ...) for 300 consecutive samples -> `lock_o` = 1 after the 4th sample; `err_cnt_o` = 0; `wrap_o` pulses at sample 256 (0xAA recurs); `period_o` = 255.
2. While locked, replace one expected sample with its bitwise inverse, then resume the correct sequence from next(corrupted value) -> `err_o` single pulse, `err_cnt_o` = 1, `lock_o` falls, relocks after 4 matches.
3. Feed 3 consecutive wrong samples after lock -> `lost_o` = 1 after the 3rd, `err_cnt_o` = 3. Drop `start_i` for one cycle then raise it -> state SEED, `err_cnt_o` = 0.
4. First sample 0x00 -> `err_o` pulses, `err_cnt_o` stays 0, the block stays in SEED. Next sample 0xAA seeds normally.
5. Correct sequence with `valid_i` low on every other cycle -> identical results to scenario 1 over 600 cycles.
6. Assert `rst_i` mid-TRACK with `err_cnt_o` = 2 -> all outputs 0 next cycle. With LFSR_CHECK_STICKY_EN, `err_sticky_o` = 1 after the errors and 0 after reset.

Source files
------------

// File: rtl/lfsr_check.sv
// lfsr_check -- receive-side checker for the 8-bit LFSR generator stream.
//
// Seeds an internal LFSR model (x^8+x^6+x^5+x^4+1, Fibonacci) from the first
// accepted nonzero sample. It then predicts every following sample and
// reports lock, mismatches, loss of sync and the measured sequence period.
// All outputs are registered. The response to a sample appears the cycle
// after the edge that accepted it.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   start_i      level enable; low returns to IDLE
//   data_i[7:0]  received sample
//   valid_i      data_i valid this cycle
//   lock_o       LOCK_CNT consecutive matches seen
//   err_o        one-cycle pulse per mismatched/rejected sample
//   err_cnt_o    saturating mismatch count since start
//   wrap_o       one-cycle pulse when the seed value recurs
//   period_o     samples between seed and its recurrence (0 until first wrap)
//   lost_o       high while in LOST
//   err_sticky_o sticky error flag
//
// Build option: define LFSR_CHECK_STICKY_EN to build the sticky error
// register. Without it, err_sticky_o is tied to 0.

module lfsr_check #(
    parameter int LOCK_CNT  = 4,
    parameter int ERR_LIMIT = 3,
    parameter int CNT_W     = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [7:0]       data_i,
    input  logic             valid_i,
    output logic             lock_o,
    output logic             err_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic             wrap_o,
    output logic [CNT_W-1:0] period_o,
    output logic             lost_o,
    output logic             err_sticky_o
);

    typedef enum logic [1:0] {S_IDLE, S_SEED, S_TRACK, S_LOST} state_t;

    localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);
    localparam logic [3:0] ERR_N  = 4'(ERR_LIMIT);

    function automatic logic [7:0] f_next(input logic [7:0] q);
        return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    endfunction

    state_t           r_state, w_state;
    logic [7:0]       r_first, w_first;
    logic [7:0]       r_exp, w_exp;
    logic [CNT_W-1:0] r_sample_cnt, w_sample_cnt;
    logic [3:0]       r_match_cnt, w_match_cnt;
    logic [3:0]       r_mis_run, w_mis_run;
    logic             r_lock, w_lock;
    logic             r_err, w_err;
    logic [CNT_W-1:0] r_err_cnt, w_err_cnt;
    logic             r_wrap, w_wrap;
    logic [CNT_W-1:0] r_period, w_period;
    logic             r_lost, w_lost;
    logic             w_seed_entry;
    logic [CNT_W-1:0] w_sample_inc;
    logic [CNT_W-1:0] w_err_inc;

    assign w_sample_inc = (r_sample_cnt == '1) ? r_sample_cnt : r_sample_cnt + 1'b1;
    assign w_err_inc    = (r_err_cnt == '1) ? r_err_cnt : r_err_cnt + 1'b1;
    assign w_seed_entry = start_i && (r_state == S_IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_first      <= '0;
            r_exp        <= '0;
            r_sample_cnt <= '0;
            r_match_cnt  <= '0;
            r_mis_run    <= '0;
            r_lock       <= 1'b0;
            r_err        <= 1'b0;
            r_err_cnt    <= '0;
            r_wrap       <= 1'b0;
            r_period     <= '0;
            r_lost       <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_first      <= w_first;
            r_exp        <= w_exp;
            r_sample_cnt <= w_sample_cnt;
            r_match_cnt  <= w_match_cnt;
            r_mis_run    <= w_mis_run;
            r_lock       <= w_lock;
            r_err        <= w_err;
            r_err_cnt    <= w_err_cnt;
            r_wrap       <= w_wrap;
            r_period     <= w_period;
            r_lost       <= w_lost;
        end
    end

    always_comb begin
        w_state      = r_state;
        w_first      = r_first;
        w_exp        = r_exp;
        w_sample_cnt = r_sample_cnt;
        w_match_cnt  = r_match_cnt;
        w_mis_run    = r_mis_run;
        w_lock       = r_lock;
        w_err        = 1'b0;
        w_err_cnt    = r_err_cnt;
        w_wrap       = 1'b0;
        w_period     = r_period;
        w_lost       = r_lost;

        if (!start_i) begin
            // Any sample on this edge is dropped; counters stay for readout.
            w_state = S_IDLE;
            w_lock  = 1'b0;
            w_lost  = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state      = S_SEED;
                    w_err_cnt    = '0;
                    w_period     = '0;
                    w_sample_cnt = '0;
                    w_match_cnt  = '0;
                    w_mis_run    = '0;
                    w_lock       = 1'b0;
                    w_lost       = 1'b0;
                end
                S_SEED: begin
                    if (valid_i) begin
                        if (data_i == 8'h00) begin
                            // All-zero is the LFSR lockup state: reject it
                            // without counting it as a mismatch.
                            w_err = 1'b1;
                        end else begin
                            w_first      = data_i;
                            w_exp        = f_next(data_i);
                            w_sample_cnt = {{(CNT_W-1){1'b0}}, 1'b1};
                            w_match_cnt  = 4'd1;
                            w_mis_run    = '0;
                            w_state      = S_TRACK;
                        end
                    end
                end
                S_TRACK: begin
                    if (valid_i) begin
                        w_sample_cnt = w_sample_inc;
                        if (data_i == r_exp) begin
                            w_exp       = f_next(r_exp);
                            w_mis_run   = '0;
                            w_match_cnt = (r_match_cnt >= LOCK_N) ? LOCK_N : r_match_cnt + 4'd1;
                            if (w_match_cnt >= LOCK_N)
                                w_lock = 1'b1;
                            // Period is the old count: seed was sample 1.
                            if (data_i == r_first && r_sample_cnt > 1) begin
                                w_wrap       = 1'b1;
                                w_period     = r_sample_cnt;
                                w_sample_cnt = {{(CNT_W-1){1'b0}}, 1'b1};
                            end
                        end else begin
                            w_err       = 1'b1;
                            w_err_cnt   = w_err_inc;
                            w_lock      = 1'b0;
                            w_match_cnt = '0;
                            w_mis_run   = r_mis_run + 4'd1;
                            // Resync on the received value so a single bit
                            // error costs exactly one mismatch.
                            w_exp       = f_next(data_i);
                            if (w_mis_run >= ERR_N) begin
                                w_state = S_LOST;
                                w_lost  = 1'b1;
                            end
                        end
                    end
                end
                S_LOST: begin
                    w_lost = 1'b1;
                    w_lock = 1'b0;
                end
                default: w_state = S_IDLE;
            endcase
        end
    end

`ifdef LFSR_CHECK_STICKY_EN
    logic r_sticky;
    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_sticky <= 1'b0;
        else if (w_seed_entry)
            r_sticky <= 1'b0;
        else if (w_err)
            r_sticky <= 1'b1;
    end
    assign err_sticky_o = r_sticky;
`else
    assign err_sticky_o = 1'b0;
`endif

    assign lock_o    = r_lock;
    assign err_o     = r_err;
    assign err_cnt_o = r_err_cnt;
    assign wrap_o    = r_wrap;
    assign period_o  = r_period;
    assign lost_o    = r_lost;

endmodule

// File: tb/tb_lfsr_check.sv
module tb_lfsr_check;

    logic        clk = 1'b0;
    logic        rst, start, valid;
    logic [7:0]  data;
    logic        lock, err, wrap, lost, sticky;
    logic [15:0] err_cnt, period;

    int n_cmp  = 0;
    int n_fail = 0;

    lfsr_check #(.LOCK_CNT(4), .ERR_LIMIT(3), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .data_i(data), .valid_i(valid),
        .lock_o(lock), .err_o(err), .err_cnt_o(err_cnt), .wrap_o(wrap),
        .period_o(period), .lost_o(lost), .err_sticky_o(sticky)
    );

    always #5 clk = ~clk;

`ifdef LFSR_CHECK_STICKY_EN
    localparam logic STICKY_ON = 1'b1;
`else
    localparam logic STICKY_ON = 1'b0;
`endif

    function automatic logic [7:0] nx(input logic [7:0] q);
        return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Drive one cycle; outputs are sampled 1 time unit after the edge.
    task automatic step(input logic s, input logic v, input logic [7:0] d);
        start = s; valid = v; data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".lock"},    32'(lock),    0);
        chk({tag, ".err"},     32'(err),     0);
        chk({tag, ".err_cnt"}, 32'(err_cnt), 0);
        chk({tag, ".wrap"},    32'(wrap),    0);
        chk({tag, ".period"},  32'(period),  0);
        chk({tag, ".lost"},    32'(lost),    0);
        chk({tag, ".sticky"},  32'(sticky),  0);
    endtask

    typedef struct {
        logic        s, v;
        logic [7:0]  d;
        logic        lock, err, lost, chk_per;
        logic [15:0] cnt, per;
    } vec_t;

    function automatic vec_t mk(logic s, logic v, logic [7:0] d, logic lk, logic e,
                                logic [15:0] c, logic ls, logic cp, logic [15:0] p);
        vec_t r;
        r.s = s; r.v = v; r.d = d; r.lock = lk; r.err = e; r.cnt = c;
        r.lost = ls; r.chk_per = cp; r.per = p;
        return r;
    endfunction

    // Runs 300 correct samples from seed 0xAA, optionally with an idle
    // cycle after each sample. Leaves v at the next expected value.
    task automatic run_seq(input string tag, input bit gaps, output logic [7:0] v);
        v = 8'hAA;
        for (int k = 1; k <= 300; k++) begin
            step(1, 1, v);
            chk({tag, ".lock"}, 32'(lock), 32'(k >= 4));
            chk({tag, ".wrap"}, 32'(wrap), 32'(k == 256));
            chk({tag, ".err"},  32'(err),  0);
            if (k == 255) chk({tag, ".period_pre"}, 32'(period), 0);
            if (gaps) begin
                step(1, 0, 8'h00);
                chk({tag, ".gap_wrap"}, 32'(wrap), 0);
                chk({tag, ".gap_lock"}, 32'(lock), 32'(k >= 4));
            end
            v = nx(v);
        end
        chk({tag, ".period"},  32'(period),  255);
        chk({tag, ".err_cnt"}, 32'(err_cnt), 0);
        chk({tag, ".lost"},    32'(lost),    0);
    endtask

    vec_t tbl[14];

    initial begin
        logic [7:0] v, c;

        // Lost-sync and zero-seed walk; starts locked with err_cnt = 1.
        tbl[0]  = mk(0, 1, 8'hAA, 0, 0, 1, 0, 0, 0);  // start falls: sample ignored
        tbl[1]  = mk(1, 0, 8'h00, 0, 0, 0, 0, 1, 0);  // IDLE->SEED clears
        tbl[2]  = mk(1, 1, 8'h00, 0, 1, 0, 0, 1, 0);  // zero seed rejected
        tbl[3]  = mk(1, 1, 8'hAA, 0, 0, 0, 0, 1, 0);  // seeds
        tbl[4]  = mk(1, 1, 8'h55, 0, 0, 0, 0, 1, 0);
        tbl[5]  = mk(1, 1, 8'hAB, 0, 0, 0, 0, 1, 0);
        tbl[6]  = mk(1, 1, 8'h57, 1, 0, 0, 0, 1, 0);  // 4th match: lock
        tbl[7]  = mk(1, 1, 8'h01, 0, 1, 1, 0, 1, 0);
        tbl[8]  = mk(1, 0, 8'h01, 0, 0, 1, 0, 1, 0);  // idle cycle
        tbl[9]  = mk(1, 1, 8'h01, 0, 1, 2, 0, 1, 0);
        tbl[10] = mk(1, 1, 8'h01, 0, 1, 3, 1, 1, 0);  // 3rd in a row: LOST
        tbl[11] = mk(1, 1, 8'h02, 0, 0, 3, 1, 1, 0);  // ignored in LOST
        tbl[12] = mk(0, 0, 8'h00, 0, 0, 3, 0, 1, 0);  // IDLE, count held
        tbl[13] = mk(1, 0, 8'h00, 0, 0, 0, 0, 1, 0);  // SEED, cleared

        rst = 1; start = 0; valid = 0; data = 8'h00;
        @(posedge clk); #1;
        step(1, 1, 8'hAA);  // reset dominates start and valid
        chk_all_zero("reset");
        rst = 0;

        // Scenario 1: clean run.
        step(1, 0, 8'h00);
        run_seq("seq", 0, v);

        // Scenario 2: one inverted sample while locked, then relock.
        while (v == 8'hFF) begin step(1, 1, v); v = nx(v); end
        c = ~v;
        step(1, 1, c);
        chk("corrupt.err",     32'(err),     1);
        chk("corrupt.err_cnt", 32'(err_cnt), 1);
        chk("corrupt.lock",    32'(lock),    0);
        v = nx(c);
        for (int k = 1; k <= 4; k++) begin
            step(1, 1, v);
            chk("relock.err",  32'(err),  0);
            chk("relock.lock", 32'(lock), 32'(k == 4));
            v = nx(v);
        end
        chk("relock.err_cnt", 32'(err_cnt), 1);
        chk("sticky.after_err", 32'(sticky), 32'(STICKY_ON));

        // Scenarios 3/4: table.
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].s, tbl[i].v, tbl[i].d);
            chk($sformatf("tbl%0d.lock", i),    32'(lock),    32'(tbl[i].lock));
            chk($sformatf("tbl%0d.err", i),     32'(err),     32'(tbl[i].err));
            chk($sformatf("tbl%0d.err_cnt", i), 32'(err_cnt), 32'(tbl[i].cnt));
            chk($sformatf("tbl%0d.lost", i),    32'(lost),    32'(tbl[i].lost));
            chk($sformatf("tbl%0d.wrap", i),    32'(wrap),    0);
            if (tbl[i].chk_per)
                chk($sformatf("tbl%0d.period", i), 32'(period), 32'(tbl[i].per));
        end
        chk("tbl.sticky_cleared", 32'(sticky), 0);

        // Scenario 5: fresh start, every other cycle idle.
        rst = 1; step(0, 0, 8'h00); rst = 0;
        step(1, 0, 8'h00);
        run_seq("gap", 1, v);
        chk("gap.sticky", 32'(sticky), 0);

        // Scenario 6: two errors mid-TRACK, then reset.
        if (v == 8'h01) begin step(1, 1, v); v = nx(v); end
        step(1, 1, 8'h01);
        step(1, 1, 8'h01);
        chk("rst6.err_cnt_pre", 32'(err_cnt), 2);
        chk("rst6.lost_pre",    32'(lost),    0);
        chk("rst6.sticky_pre",  32'(sticky),  32'(STICKY_ON));
        rst = 1;
        step(1, 1, 8'h55);
        chk_all_zero("rst6");
        rst = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
